imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer between the IF stage's dual-instruction request (pc, pc+4, valid) and a single-ported, variable-latency instruction memory that returns one 32-bit word per transaction. It issues two sequential word reads, buffers both words, and presents them to IF with a ready flag, which drives IF's imem_miss. It discards in-flight fetches on a branch-redirect flush and keeps a saturating count of fetch-stall cycles.

Parameters:
ADDR_WIDTH, 32, width of fetch addresses
CNT_WIDTH, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  IF fetch request valid (instr_req.valid)
req_pc0  in  ADDR_WIDTH  instr0 address (instr_req.instr0)
req_pc1  in  ADDR_WIDTH  instr1 address (instr_req.instr1)
flush  in  1  branch redirect from EX (flush_valid)
consume  in  1  IF accepts the buffered pair this cycle (~IF_stall)
mem_req_valid  out  1  memory read request
mem_req_addr  out  ADDR_WIDTH  memory read address
mem_req_ready  in  1  memory accepts the request
mem_resp_valid  in  1  read data valid, one pulse per accepted request, in order
mem_resp_data  in  32  read data
instr_resp_ready  out  1  buffered pair valid, to IF
imem_data_instr0  out  32  word at the latched pc0
imem_data_instr1  out  32  word at the latched pc1
busy  out  1  state is not IDLE
stall_cycles  out  CNT_WIDTH  saturating count of cycles with req_valid=1 and instr_resp_ready=0

Behaviour:
- Reset: state=IDLE. mem_req_valid=0, mem_req_addr=0, instr_resp_ready=0, both data words=0, busy=0, stall_cycles=0. Reset wins over every other input in the same cycle, including mid-transaction. The memory shares this reset, so no stale response survives it.
- At most one memory transaction is outstanding at a time.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- IDLE: if req_valid and not flush, latch req_pc0 and req_pc1, then go to REQ0. Otherwise stay.
- REQ0: mem_req_valid=1, mem_req_addr=latched pc0. Once asserted, valid and address are held stable until mem_req_ready. On the handshake go to WAIT0.
- WAIT0: on mem_resp_valid, capture data into imem_data_instr0 and go to REQ1.
- REQ1 and WAIT1: same as REQ0 and WAIT0 using latched pc1; the captured data goes to imem_data_instr1. WAIT1 goes to DONE.
- DONE: instr_resp_ready=1 and the data words are held stable. On consume go to IDLE. The next pair is sampled no earlier than the following cycle, so best-case request-to-ready latency is 4 cycles plus memory latency.
- Flush in IDLE or DONE: go to IDLE, deassert instr_resp_ready, and do not latch the new request that cycle.
- Flush in REQ0 or REQ1: the request is not withdrawn. Set the drop flag and stay in the state until mem_req_ready, then go to DRAIN.
- Flush in WAIT0 or WAIT1: go to DRAIN, unless mem_resp_valid arrives in the same cycle. In that case the response is discarded and the state goes to IDLE.
- Flush on the same cycle as the mem_req_ready handshake: go to DRAIN.
- DRAIN: mem_req_valid=0. Discard one mem_resp_valid, then go to IDLE. A flush received while in DRAIN has no additional effect.
- No data word captured after a flush is ever presented to IF.
- Flush and consume in DONE in the same cycle: go to IDLE (same result either way).
- req_valid dropping in REQx or WAITx does not abort the fetch; only flush or reset aborts.
- stall_cycles increments by 1 each cycle that req_valid=1 and instr_resp_ready=0, saturates at 2^CNT_WIDTH-1, and clears only on reset.
- busy = (state != IDLE).

Test Plan:
- Basic fetch: req pc0=0x100, pc1=0x104, memory with 1-cycle accept and 2-cycle response returning 0xAAAA0001 and 0xAAAA0002 -> mem_req_addr sequence 0x100 then 0x104; instr_resp_ready rises with instr0=0xAAAA0001 and instr1=0xAAAA0002; consume returns the block to IDLE.
- Held request: mem_req_ready low for 5 cycles in REQ0 -> mem_req_valid=1 and addr=0x100 stable throughout; one transaction issued.
- Flush in WAIT1: flush one cycle before the second response, which is 0xDEAD -> response discarded; instr_resp_ready never asserted for that pair; next request at 0x200 fetches correctly.
- Flush during REQ0 backpressure: after the handshake, state is DRAIN and exactly one response is dropped; the following fetch data is correct.
- Stall in DONE: consume=0 for 10 cycles -> data and ready held stable; no memory requests issued.
- Reset mid-WAIT0 -> next cycle all outputs zero and state IDLE. Separately, with CNT_WIDTH=4 and 20 stalled cycles, stall_cycles saturates at 15.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: turns one IF dual-instruction request into two sequential word reads
// on a single-ported, variable-latency instruction memory, with flush and stall accounting.
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_pc0,
    input  logic [ADDR_WIDTH-1:0] req_pc1,
    input  logic                  flush,
    input  logic                  consume,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data,
    output logic                  instr_resp_ready,
    output logic [31:0]           imem_data_instr0,
    output logic [31:0]           imem_data_instr1,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StDone,
        StDrain
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc0_q;
    logic [ADDR_WIDTH-1:0] pc1_q;
    logic                  drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            pc0_q            <= '0;
            pc1_q            <= '0;
            drop_q           <= 1'b0;
            mem_req_valid    <= 1'b0;
            mem_req_addr     <= '0;
            instr_resp_ready <= 1'b0;
            imem_data_instr0 <= '0;
            imem_data_instr1 <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && !flush) begin
                        pc0_q         <= req_pc0;
                        pc1_q         <= req_pc1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= req_pc0;
                        state_q       <= StReq0;
                    end
                end
                StReq0, StReq1: begin
                    // A request once offered is never withdrawn; a flush only marks it for drop.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        drop_q        <= 1'b0;
                        if (flush || drop_q) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= (state_q == StReq0) ? StWait0 : StWait1;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                StWait0: begin
                    if (mem_resp_valid) begin
                        if (flush) begin
                            state_q <= StIdle;
                        end else begin
                            imem_data_instr0 <= mem_resp_data;
                            mem_req_valid    <= 1'b1;
                            mem_req_addr     <= pc1_q;
                            state_q          <= StReq1;
                        end
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StWait1: begin
                    if (mem_resp_valid) begin
                        if (flush) begin
                            state_q <= StIdle;
                        end else begin
                            imem_data_instr1 <= mem_resp_data;
                            instr_resp_ready <= 1'b1;
                            state_q          <= StDone;
                        end
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDone: begin
                    if (flush || consume) begin
                        instr_resp_ready <= 1'b0;
                        state_q          <= StIdle;
                    end
                end
                StDrain: begin
                    if (mem_resp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    mem_req_valid    <= 1'b0;
                    instr_resp_ready <= 1'b0;
                    state_q          <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (req_valid && !instr_resp_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small variable-latency memory responder;
// a second narrow-counter instance checks stall counter saturation.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc0;
    logic [31:0] req_pc1;
    logic        flush;
    logic        consume;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = '0;
    logic        instr_resp_ready;
    logic [31:0] imem_data_instr0;
    logic [31:0] imem_data_instr1;
    logic        busy;
    logic [15:0] stall_cycles;

    logic        n_mem_req_valid;
    logic [31:0] n_mem_req_addr;
    logic        n_instr_resp_ready;
    logic [31:0] n_imem_data_instr0;
    logic [31:0] n_imem_data_instr1;
    logic        n_busy;
    logic [3:0]  n_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder configuration (written by the stimulus) and state (written by the model).
    int          ready_hold = 0;
    int          resp_lat   = 1;
    logic [31:0] data_rom[$];
    logic [31:0] addr_log[$];
    int          req_count  = 0;
    int          resp_idx   = 0;
    int          resp_cd    = 0;
    int          hold_cnt   = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_pc0          (req_pc0),
        .req_pc1          (req_pc1),
        .flush            (flush),
        .consume          (consume),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .instr_resp_ready (instr_resp_ready),
        .imem_data_instr0 (imem_data_instr0),
        .imem_data_instr1 (imem_data_instr1),
        .busy             (busy),
        .stall_cycles     (stall_cycles)
    );

    imem_fetch_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) u_dut_narrow (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_pc0          (req_pc0),
        .req_pc1          (req_pc1),
        .flush            (flush),
        .consume          (consume),
        .mem_req_valid    (n_mem_req_valid),
        .mem_req_addr     (n_mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .instr_resp_ready (n_instr_resp_ready),
        .imem_data_instr0 (n_imem_data_instr0),
        .imem_data_instr1 (n_imem_data_instr1),
        .busy             (n_busy),
        .stall_cycles     (n_stall_cycles)
    );

    // Accepts after ready_hold cycles of a pending request; responds resp_lat+1 edges later.
    assign mem_req_ready = mem_req_valid && (hold_cnt >= ready_hold);

    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (reset) begin
            resp_cd  <= 0;
            hold_cnt <= 0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                addr_log.push_back(mem_req_addr);
                req_count <= req_count + 1;
                resp_cd   <= resp_lat;
                hold_cnt  <= 0;
            end else begin
                hold_cnt <= mem_req_valid ? hold_cnt + 1 : 0;
                if (resp_cd > 0) resp_cd <= resp_cd - 1;
            end
            if (resp_cd == 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= data_rom[resp_idx];
                resp_idx       <= resp_idx + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, output int cycles);
        cycles = 0;
        while (!instr_resp_ready && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, instr_resp_ready, 1'b1);
    endtask

    // Waits for the WAITx state of the given address: address presented, request retired.
    task automatic wait_resp_phase(input string tag, input logic [31:0] addr);
        int n = 0;
        while (!(mem_req_addr == addr && !mem_req_valid && busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (mem_req_addr == addr) && !mem_req_valid && busy, 1'b1);
    endtask

    task automatic release_pair();
        req_valid = 1'b0;
        consume   = 1'b1;
        @(negedge clk);
        consume   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int idx0;
        int s0;
        bit ok;

        reset = 1'b1; req_valid = 1'b0; req_pc0 = '0; req_pc1 = '0;
        flush = 1'b0; consume = 1'b0;
        repeat (2) @(negedge clk);

        check("rst mem_req_valid", mem_req_valid, 0);
        check("rst mem_req_addr", mem_req_addr, 0);
        check("rst instr_resp_ready", instr_resp_ready, 0);
        check("rst instr0", imem_data_instr0, 0);
        check("rst instr1", imem_data_instr1, 0);
        check("rst busy", busy, 0);
        check("rst stall_cycles", stall_cycles, 0);
        reset = 1'b0;

        // Basic fetch: immediate accept, response 2 edges after acceptance.
        data_rom.push_back(32'hAAAA0001);
        data_rom.push_back(32'hAAAA0002);
        resp_lat = 2; ready_hold = 0; base = req_count;
        req_valid = 1'b1; req_pc0 = 32'h100; req_pc1 = 32'h104;
        wait_ready("basic ready", cyc);
        check("basic latency", cyc, 9);
        check("basic instr0", imem_data_instr0, 32'hAAAA0001);
        check("basic instr1", imem_data_instr1, 32'hAAAA0002);
        check("basic txn count", req_count - base, 2);
        check("basic addr0", addr_log[base], 32'h100);
        check("basic addr1", addr_log[base+1], 32'h104);
        release_pair();
        check("basic consume ready", instr_resp_ready, 0);
        check("basic consume busy", busy, 0);

        // Held request under backpressure.
        data_rom.push_back(32'h11111111);
        data_rom.push_back(32'h22222222);
        resp_lat = 1; ready_hold = 5; base = req_count;
        req_valid = 1'b1; req_pc0 = 32'h100; req_pc1 = 32'h104;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ok &= mem_req_valid && (mem_req_addr == 32'h100);
        end
        check("held valid+addr stable", ok, 1);
        check("held no handshake yet", req_count - base, 0);
        wait_ready("held ready", cyc);
        check("held txn count", req_count - base, 2);
        check("held addr0", addr_log[base], 32'h100);
        check("held instr0", imem_data_instr0, 32'h11111111);
        check("held instr1", imem_data_instr1, 32'h22222222);

        // Stall in DONE: pair held, no new traffic, no stall counting while ready.
        s0 = int'(stall_cycles); base = req_count; ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok &= instr_resp_ready && !mem_req_valid
                  && (imem_data_instr0 == 32'h11111111) && (imem_data_instr1 == 32'h22222222);
        end
        check("done hold stable", ok, 1);
        check("done no requests", req_count - base, 0);
        check("done stall frozen", stall_cycles, s0);
        release_pair();
        ready_hold = 0;

        // Flush one cycle before the second response.
        data_rom.push_back(32'h33333333);
        data_rom.push_back(32'h0000DEAD);
        resp_lat = 3; idx0 = resp_idx;
        req_valid = 1'b1; req_pc0 = 32'h300; req_pc1 = 32'h304;
        wait_resp_phase("wait1 reached", 32'h304);
        repeat (2) @(negedge clk);
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ok |= instr_resp_ready;
            @(negedge clk);
        end
        check("wait1 flush no ready", ok, 0);
        check("wait1 flush idle", busy, 0);
        check("wait1 flush resp drained", resp_idx - idx0, 2);
        data_rom.push_back(32'h44444444);
        data_rom.push_back(32'h55555555);
        resp_lat = 1; base = req_count;
        req_valid = 1'b1; req_pc0 = 32'h200; req_pc1 = 32'h204;
        wait_ready("post-flush ready", cyc);
        check("post-flush instr0", imem_data_instr0, 32'h44444444);
        check("post-flush instr1", imem_data_instr1, 32'h55555555);
        check("post-flush addr0", addr_log[base], 32'h200);
        release_pair();

        // Flush during REQ0 backpressure: request held, then one response dropped.
        data_rom.push_back(32'h0000BEEF);
        data_rom.push_back(32'h66666666);
        data_rom.push_back(32'h77777777);
        ready_hold = 4; resp_lat = 2; base = req_count; idx0 = resp_idx;
        req_valid = 1'b1; req_pc0 = 32'h400; req_pc1 = 32'h404;
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("req0 flush req held", mem_req_valid && (mem_req_addr == 32'h400), 1);
        cyc = 0;
        while (mem_req_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req0 flush drain busy", busy, 1);
        check("req0 flush one txn", req_count - base, 1);
        cyc = 0;
        while (busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req0 flush idle", busy, 0);
        check("req0 flush one dropped", resp_idx - idx0, 1);
        check("req0 flush no ready", instr_resp_ready, 0);
        ready_hold = 0; resp_lat = 1;
        req_valid = 1'b1; req_pc0 = 32'h500; req_pc1 = 32'h504;
        wait_ready("req0 next ready", cyc);
        check("req0 next instr0", imem_data_instr0, 32'h66666666);
        check("req0 next instr1", imem_data_instr1, 32'h77777777);
        check("req0 next addr", addr_log[base+1], 32'h500);
        release_pair();

        // Reset in WAIT0.
        data_rom.push_back(32'h88888888);
        data_rom.push_back(32'h99999999);
        resp_lat = 4;
        req_valid = 1'b1; req_pc0 = 32'h600; req_pc1 = 32'h604;
        wait_resp_phase("wait0 reached", 32'h600);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("mid rst mem_req_valid", mem_req_valid, 0);
        check("mid rst mem_req_addr", mem_req_addr, 0);
        check("mid rst ready", instr_resp_ready, 0);
        check("mid rst instr0", imem_data_instr0, 0);
        check("mid rst instr1", imem_data_instr1, 0);
        check("mid rst busy", busy, 0);
        check("mid rst stall", stall_cycles, 0);
        check("mid rst narrow stall", n_stall_cycles, 0);

        // 20 stalled cycles: wide counter reads 20, 4-bit counter saturates at 15.
        reset = 1'b0; ready_hold = 1000;
        req_valid = 1'b1; req_pc0 = 32'h700; req_pc1 = 32'h704;
        repeat (20) @(negedge clk);
        check("stall count wide", stall_cycles, 20);
        check("stall count saturated", n_stall_cycles, 15);
        check("stall held request", mem_req_valid && (mem_req_addr == 32'h700), 1);

        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
